// File: rtl/bcd_counter_pkg.sv
// Shared types and constants for the two-digit BCD counter.
// The optional down-count feature is controlled by BCD_COUNTER_DOWN_EN (see bcd_counter.sv).
package bcd_counter_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUNNING = 2'd1,
    DONE    = 2'd2
  } bcd_state_t;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit (0-9) with up/down stepping, parallel load and synchronous clear.
// carry flags the digit sitting at its rollover limit for the current direction.
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   down,
  input  logic                   load,
  input  logic [BCD_DIGIT_W-1:0] load_val,
  input  logic                   clear,
  output logic [BCD_DIGIT_W-1:0] value,
  output logic                   carry
);

  logic [BCD_DIGIT_W-1:0] value_next;

  always_comb begin
    if (down) begin
      carry = (value == 4'd0);
    end else begin
      carry = (value == BCD_DIGIT_MAX);
    end
  end

  // Priority: clear, then load, then step; a step past the limit wraps within 0-9.
  always_comb begin
    value_next = value;
    if (clear) begin
      value_next = 4'd0;
    end else if (load) begin
      value_next = load_val;
    end else if (en) begin
      if (down) begin
        if (value == 4'd0) begin
          value_next = BCD_DIGIT_MAX;
        end else begin
          value_next = value - 4'd1;
        end
      end else begin
        if (value >= BCD_DIGIT_MAX) begin
          value_next = 4'd0;
        end else begin
          value_next = value + 4'd1;
        end
      end
    end else begin
      value_next = value;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value <= 4'd0;
    end else begin
      value <= value_next;
    end
  end

endmodule

// File: rtl/bcd_counter.sv
// Two-digit BCD stopwatch/seconds counter with start/stop, clear and a terminal value.
// Define BCD_COUNTER_DOWN_EN to add the `down` port and decrementing counts.
module bcd_counter
  import bcd_counter_pkg::*;
#(
  parameter int MAX_TENS = 5,
  parameter int MAX_ONES = 9,
  parameter bit WRAP     = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   tick,
  input  logic                   start_stop,
  input  logic                   clear,
`ifdef BCD_COUNTER_DOWN_EN
  input  logic                   down,
`endif
  output logic [BCD_DIGIT_W-1:0] ones,
  output logic [BCD_DIGIT_W-1:0] tens,
  output logic                   carry_out,
  output logic                   running
);

  if (MAX_TENS < 0 || MAX_TENS > 9 || MAX_ONES < 0 || MAX_ONES > 9) begin : g_param_check
    $error("bcd_counter: MAX_TENS and MAX_ONES must be in 0..9");
  end

  localparam logic [BCD_DIGIT_W-1:0] MAX_T = 4'(MAX_TENS);
  localparam logic [BCD_DIGIT_W-1:0] MAX_O = 4'(MAX_ONES);

  bcd_state_t             state, state_next;
  logic                   start_stop_q;
  logic                   ss_re, dir, count, terminal, carry_next;
  logic                   wrap_load, dig_clear, ones_en, tens_en;
  logic                   ones_carry, tens_carry;
  logic [BCD_DIGIT_W-1:0] ones_load, tens_load;

`ifdef BCD_COUNTER_DOWN_EN
  assign dir = down;
`else
  assign dir = 1'b0;
`endif

  assign ss_re = start_stop & ~start_stop_q;
  assign count = (state == RUNNING) & tick & ~clear;

  // Going down, 00 is the terminal value; going up it is the programmed {MAX_TENS,MAX_ONES}.
  assign terminal  = dir ? (ones_carry & tens_carry) : ((tens == MAX_T) & (ones == MAX_O));
  assign wrap_load = count & terminal & WRAP;
  assign ones_en   = count & ~terminal;
  assign tens_en   = ones_en & ones_carry;
  assign dig_clear = clear | ((state == DONE) & ss_re);
  assign ones_load = dir ? MAX_O : 4'd0;
  assign tens_load = dir ? MAX_T : 4'd0;

  bcd_digit u_ones (
    .clock    (clock),
    .reset_n  (reset_n),
    .en       (ones_en),
    .down     (dir),
    .load     (wrap_load),
    .load_val (ones_load),
    .clear    (dig_clear),
    .value    (ones),
    .carry    (ones_carry)
  );

  bcd_digit u_tens (
    .clock    (clock),
    .reset_n  (reset_n),
    .en       (tens_en),
    .down     (dir),
    .load     (wrap_load),
    .load_val (tens_load),
    .clear    (dig_clear),
    .value    (tens),
    .carry    (tens_carry)
  );

  // A saturating terminal tick wins over a simultaneous stop request.
  always_comb begin
    state_next = state;
    carry_next = 1'b0;
    if (clear) begin
      if (state == DONE) begin
        state_next = STOPPED;
      end else begin
        state_next = state;
      end
    end else begin
      case (state)
        STOPPED: begin
          if (ss_re) begin
            state_next = RUNNING;
          end else begin
            state_next = STOPPED;
          end
        end
        RUNNING: begin
          carry_next = tick & terminal;
          if (tick & terminal & ~WRAP) begin
            state_next = DONE;
          end else if (ss_re) begin
            state_next = STOPPED;
          end else begin
            state_next = RUNNING;
          end
        end
        DONE: begin
          if (ss_re) begin
            state_next = RUNNING;
          end else begin
            state_next = DONE;
          end
        end
        default: begin
          state_next = STOPPED;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= STOPPED;
      start_stop_q <= 1'b0;
      carry_out    <= 1'b0;
      running      <= 1'b0;
    end else begin
      state        <= state_next;
      start_stop_q <= start_stop;
      carry_out    <= carry_next;
      running      <= (state_next == RUNNING);
    end
  end

endmodule

// File: tb/tb_bcd_counter.sv
// Self-checking bench: a wrapping (WRAP=1) and a saturating (WRAP=0) counter, both 00-59,
// driven in lockstep and compared against an integer-valued reference model.
module tb_bcd_counter;

  localparam int MAXV = 59;

  logic       clock = 1'b0;
  logic       reset_n, tick, start_stop, clear, down;
  logic [3:0] ones_w, tens_w, ones_s, tens_s;
  logic       co_w, run_w, co_s, run_s;

  int m_val[2];
  int m_st[2];   // 0 stopped, 1 running, 2 done
  bit m_co[2];
  bit m_ssq[2];
  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  bcd_counter #(.MAX_TENS(5), .MAX_ONES(9), .WRAP(1'b1)) dut_wrap (
    .clock(clock), .reset_n(reset_n), .tick(tick), .start_stop(start_stop), .clear(clear),
`ifdef BCD_COUNTER_DOWN_EN
    .down(down),
`endif
    .ones(ones_w), .tens(tens_w), .carry_out(co_w), .running(run_w)
  );

  bcd_counter #(.MAX_TENS(5), .MAX_ONES(9), .WRAP(1'b0)) dut_sat (
    .clock(clock), .reset_n(reset_n), .tick(tick), .start_stop(start_stop), .clear(clear),
`ifdef BCD_COUNTER_DOWN_EN
    .down(down),
`endif
    .ones(ones_s), .tens(tens_s), .carry_out(co_s), .running(run_s)
  );

  function automatic logic [9:0] obs_vec(int k);
    if (k == 0) return {tens_w, ones_w, co_w, run_w};
    else        return {tens_s, ones_s, co_s, run_s};
  endfunction

  function automatic logic [9:0] exp_vec(int k);
    return {4'(m_val[k] / 10), 4'(m_val[k] % 10), m_co[k], (m_st[k] == 1)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_val[k] = 0; m_st[k] = 0; m_co[k] = 1'b0; m_ssq[k] = 1'b0;
    end
  endtask

  // Reference behaviour on one clock edge, using the inputs held before that edge.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit re;
      re = start_stop && !m_ssq[k];
      m_ssq[k] = start_stop;
      m_co[k] = 1'b0;
      if (clear) begin
        m_val[k] = 0;
        if (m_st[k] == 2) m_st[k] = 0;
      end else if (m_st[k] == 0) begin
        if (re) m_st[k] = 1;
      end else if (m_st[k] == 2) begin
        if (re) begin m_val[k] = 0; m_st[k] = 1; end
      end else begin
        if (tick) begin
          if ((!down && m_val[k] == MAXV) || (down && m_val[k] == 0)) begin
            m_co[k] = 1'b1;
            if (k == 0) m_val[k] = down ? MAXV : 0;
            else        m_st[k] = 2;
          end else begin
            m_val[k] = down ? m_val[k] - 1 : m_val[k] + 1;
          end
        end
        if (re && m_st[k] == 1) m_st[k] = 0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; tick = 1'b0; start_stop = 1'b0; clear = 1'b0; down = 1'b0;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic ss_pulse();
    start_stop = 1'b1; cyc();
    start_stop = 1'b0; cyc();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tick = 1'b0; start_stop = 1'b0; clear = 1'b0; down = 1'b0;
    model_reset();
    #2;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs_vec(k) !== 10'd0) begin
        bad++;
        $display("FAIL reset dut%0d got=%h exp=%h", k, obs_vec(k), 10'd0);
      end
    end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_count3();
    do_reset();
    ss_pulse();
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1; cyc();
      tick = 1'b0; cyc();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs_vec(k) !== exp_vec(k)) begin
          bad++;
          $display("FAIL count3 dut%0d step%0d got=%h exp=%h", k, i, obs_vec(k), exp_vec(k));
        end
      end
    end
    total++;
    if ({tens_w, ones_w, co_w, run_w} !== {4'd0, 4'd3, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL count3_final got=%h exp=%h", {tens_w, ones_w, co_w, run_w}, {4'd0, 4'd3, 1'b0, 1'b1});
    end
  endtask

  task automatic test_wrap_sat();
    do_reset();
    ss_pulse();
    tick = 1'b1;
    for (int i = 0; i < 62; i++) begin
      cyc();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs_vec(k) !== exp_vec(k)) begin
          bad++;
          $display("FAIL wrap_run dut%0d tick%0d got=%h exp=%h", k, i, obs_vec(k), exp_vec(k));
        end
      end
      if (i == 9) begin
        total++;
        if ({tens_w, ones_w} !== 8'h10) begin
          bad++; $display("FAIL ones_to_tens got=%h exp=10", {tens_w, ones_w});
        end
      end
      if (i == 59) begin
        total++;
        if ({tens_w, ones_w, co_w, tens_s, ones_s, co_s, run_s} !== {8'h00, 1'b1, 8'h59, 1'b1, 1'b0}) begin
          bad++;
          $display("FAIL terminal got=%h exp=%h", {tens_w, ones_w, co_w, tens_s, ones_s, co_s, run_s},
                   {8'h00, 1'b1, 8'h59, 1'b1, 1'b0});
        end
      end
      if (i == 61) begin
        total++;
        if ({tens_s, ones_s, co_s, run_s, co_w} !== {8'h59, 1'b0, 1'b0, 1'b0}) begin
          bad++;
          $display("FAIL saturate_hold got=%h exp=%h", {tens_s, ones_s, co_s, run_s, co_w}, {8'h59, 3'b000});
        end
      end
    end
    tick = 1'b0;
    start_stop = 1'b1; cyc();
    start_stop = 1'b0;
    total++;
    if ({tens_s, ones_s, run_s} !== {8'h00, 1'b1}) begin
      bad++; $display("FAIL done_restart got=%h exp=%h", {tens_s, ones_s, run_s}, {8'h00, 1'b1});
    end
  endtask

  task automatic test_ss_tick();
    do_reset();
    start_stop = 1'b1; tick = 1'b1; cyc();
    total++;
    if ({tens_w, ones_w, run_w} !== {8'h00, 1'b1}) begin
      bad++; $display("FAIL ss_tick_stopped got=%h exp=%h", {tens_w, ones_w, run_w}, {8'h00, 1'b1});
    end
    start_stop = 1'b0; tick = 1'b0; cyc();
    start_stop = 1'b1; tick = 1'b1; cyc();
    total++;
    if ({tens_w, ones_w, run_w} !== {8'h01, 1'b0}) begin
      bad++; $display("FAIL ss_tick_running got=%h exp=%h", {tens_w, ones_w, run_w}, {8'h01, 1'b0});
    end
    start_stop = 1'b0; tick = 1'b0; cyc();
    start_stop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs_vec(k) !== exp_vec(k)) begin
          bad++;
          $display("FAIL ss_hold dut%0d cyc%0d got=%h exp=%h", k, i, obs_vec(k), exp_vec(k));
        end
      end
    end
    total++;
    if (run_w !== 1'b1) begin
      bad++; $display("FAIL ss_hold_once got=%b exp=1", run_w);
    end
    start_stop = 1'b0; cyc();
  endtask

  task automatic test_clear();
    do_reset();
    ss_pulse();
    tick = 1'b1;
    repeat (37) cyc();
    total++;
    if ({tens_w, ones_w, tens_s, ones_s} !== 16'h3737) begin
      bad++; $display("FAIL reach37 got=%h exp=3737", {tens_w, ones_w, tens_s, ones_s});
    end
    clear = 1'b1; cyc();
    clear = 1'b0; tick = 1'b0;
    total++;
    if ({tens_w, ones_w, co_w, run_w} !== {8'h00, 1'b0, 1'b1}) begin
      bad++; $display("FAIL clear_tick got=%h exp=%h", {tens_w, ones_w, co_w, run_w}, {8'h00, 1'b0, 1'b1});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    ss_pulse();
    tick = 1'b1;
    repeat (5) cyc();
    tick = 1'b0;
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs_vec(k) !== 10'd0) begin
        bad++; $display("FAIL async_reset dut%0d got=%h exp=%h", k, obs_vec(k), 10'd0);
      end
    end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
  endtask

`ifdef BCD_COUNTER_DOWN_EN
  task automatic test_down();
    do_reset();
    ss_pulse();
    tick = 1'b1;
    repeat (10) cyc();
    down = 1'b1; cyc();
    total++;
    if ({tens_w, ones_w} !== 8'h09) begin
      bad++; $display("FAIL down_borrow got=%h exp=09", {tens_w, ones_w});
    end
    do_reset();
    ss_pulse();
    down = 1'b1; tick = 1'b1; cyc();
    tick = 1'b0; down = 1'b0;
    total++;
    if ({tens_w, ones_w, co_w, tens_s, ones_s, co_s, run_s} !== {8'h59, 1'b1, 8'h00, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL down_terminal got=%h exp=%h", {tens_w, ones_w, co_w, tens_s, ones_s, co_s, run_s},
               {8'h59, 1'b1, 8'h00, 1'b1, 1'b0});
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      tick  = ($urandom_range(2, 0) != 0);
      clear = ($urandom_range(59, 0) == 0);
      if ($urandom_range(7, 0) == 0) start_stop = ~start_stop;
`ifdef BCD_COUNTER_DOWN_EN
      if ($urandom_range(29, 0) == 0) down = ~down;
`endif
      cyc();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs_vec(k) !== exp_vec(k)) begin
          bad++;
          $display("FAIL random dut%0d cyc%0d got=%h exp=%h", k, i, obs_vec(k), exp_vec(k));
        end
      end
    end
    tick = 1'b0; clear = 1'b0; start_stop = 1'b0; down = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count3();
    test_wrap_sat();
    test_ss_tick();
    test_clear();
    test_async_reset();
`ifdef BCD_COUNTER_DOWN_EN
    test_down();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
